// File: rtl/pp_pkg.sv
// Shared definitions for the pp sample-processing chain (pplimit and
// downstream blocks): default widths and the unsigned max helper.
package pp_pkg;

  localparam int PP_DW        = 7;
  localparam int PP_LOG2N_MAX = 8;

  // Unsigned maximum of two values. The operands are 32 bits wide so that
  // any instance width up to 32 can use it; callers cast back to their width.
  function automatic logic [31:0] pp_max(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_decim_avg.sv
// Strobe-qualified block averager with peak hold. Every 2^LOG2N strobed
// samples it publishes the window mean (truncated or rounded half-up) and the
// window maximum, marked by a one-cycle strobe_out. clear restarts the window
// without touching the published values.
module pp_decim_avg
  import pp_pkg::*;
#(
  parameter int DW    = PP_DW,
  parameter int LOG2N = 3,
  parameter int ROUND = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in,
  input  logic          strobe_in,
  input  logic          clear,
  output logic [DW-1:0] out,
  output logic [DW-1:0] peak,
  output logic          strobe_out
);

  // Accumulator holds N samples of DW bits; the sum with the incoming sample
  // gets one extra bit so the rounding offset can never wrap.
  localparam int AW = DW + LOG2N;
  localparam int SW = AW + 1;
  // With LOG2N=0 the counter collapses to a single bit that stays at 0, so
  // "last sample" is always true and every strobe completes a window.
  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2N) - 1);
  // N/2 rounding offset; zero for truncation and for N=1.
  localparam logic [SW-1:0] RND = (ROUND != 0) ? SW'((1 << LOG2N) >> 1) : '0;

  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] pk_q, pk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] peak_q, peak_d;
  logic          strobe_q, strobe_d;

  logic [SW-1:0] sum_s;
  logic [SW-1:0] mean_s;
  logic [DW-1:0] max_s;

  // Window update: clear wins over a coincident sample, the Nth sample
  // publishes mean/peak and restarts the window, otherwise accumulate.
  always_comb begin
    acc_d    = acc_q;
    pk_d     = pk_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    peak_d   = peak_q;
    strobe_d = 1'b0;
    sum_s    = SW'(acc_q) + SW'(in);
    mean_s   = (sum_s + RND) >> LOG2N;
    max_s    = DW'(pp_max(32'(pk_q), 32'(in)));

    if (clear) begin
      acc_d = '0;
      pk_d  = '0;
      cnt_d = '0;
    end else if (strobe_in) begin
      if (cnt_q == CNT_LAST) begin
        out_d    = mean_s[DW-1:0];
        peak_d   = max_s;
        strobe_d = 1'b1;
        acc_d    = '0;
        pk_d     = '0;
        cnt_d    = '0;
      end else begin
        acc_d = sum_s[AW-1:0];
        pk_d  = max_s;
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      pk_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      peak_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      pk_q     <= pk_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      peak_q   <= peak_d;
      strobe_q <= strobe_d;
    end
  end

  assign out        = out_q;
  assign peak       = peak_q;
  assign strobe_out = strobe_q;

endmodule

// File: tb/tb_pp_decim_avg.sv
// Bench for pp_decim_avg: three instances (N=8 truncating, N=8 rounding,
// N=1 pass-through) share one stimulus stream and are compared each cycle
// against a window-list reference model, plus a directed vector table and a
// mid-window reset sequence.
module tb_pp_decim_avg;

  logic       clk;
  logic       rst_n;
  logic [6:0] in;
  logic       strobe_in;
  logic       clear;

  logic [6:0] out_t, peak_t, out_r, peak_r, out_1, peak_1;
  logic       so_t, so_r, so_1;

  pp_decim_avg #(.DW(7), .LOG2N(3), .ROUND(0)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .strobe_in(strobe_in), .clear(clear),
    .out(out_t), .peak(peak_t), .strobe_out(so_t));

  pp_decim_avg #(.DW(7), .LOG2N(3), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in(in), .strobe_in(strobe_in), .clear(clear),
    .out(out_r), .peak(peak_r), .strobe_out(so_r));

  pp_decim_avg #(.DW(7), .LOG2N(0), .ROUND(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in(in), .strobe_in(strobe_in), .clear(clear),
    .out(out_1), .peak(peak_1), .strobe_out(so_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the list of samples in the current window.
  int win[$];
  int m_out_t, m_out_r, m_peak, m_so;
  int m_out_1, m_so_1;

  typedef struct {
    int v;
    bit s;
    bit c;
    int gap;
    bit so;
    int o;
    int orr;
    int p;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_out_t = 0; m_out_r = 0; m_peak = 0; m_so = 0;
    m_out_1 = 0; m_so_1 = 0;
  endtask

  task automatic model_step(input int v, input bit s, input bit c);
    int sum;
    int mx;
    m_so   = 0;
    m_so_1 = 0;
    if (c) begin
      win.delete();
    end else if (s) begin
      m_out_1 = v;
      m_so_1  = 1;
      win.push_back(v);
      if (win.size() == 8) begin
        sum = 0;
        mx  = 0;
        foreach (win[k]) begin
          sum += win[k];
          if (win[k] > mx) mx = win[k];
        end
        m_out_t = sum / 8;
        m_out_r = (sum + 4) / 8;
        m_peak  = mx;
        m_so    = 1;
        win.delete();
      end
    end
  endtask

  task automatic check_model();
    chk("so_trunc",  so_t,   m_so);
    chk("out_trunc", out_t,  m_out_t);
    chk("peak_trunc", peak_t, m_peak);
    chk("so_round",  so_r,   m_so);
    chk("out_round", out_r,  m_out_r);
    chk("peak_round", peak_r, m_peak);
    chk("so_n1",     so_1,   m_so_1);
    chk("out_n1",    out_1,  m_out_1);
    chk("peak_n1",   peak_1, m_out_1);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input int v, input bit s, input bit c);
    in        = 7'(v);
    strobe_in = s;
    clear     = c;
    @(posedge clk);
    model_step(v, s, c);
    #1;
    check_model();
  endtask

  task automatic add(input int v, input bit s, input bit c, input int gap,
                     input bit so, input int o, input int orr, input int p);
    vec_t e;
    e.v = v; e.s = s; e.c = c; e.gap = gap; e.so = so; e.o = o; e.orr = orr; e.p = p;
    tbl.push_back(e);
  endtask

  initial begin
    // Directed table: samples 0..7 sparse, two back-to-back 127 windows,
    // clear after a partial window, and clear coincident with the 8th sample.
    for (int i = 0; i < 8; i++)
      add(i, 1, 0, 9, i == 7, (i == 7) ? 3 : 0, (i == 7) ? 4 : 0, (i == 7) ? 7 : 0);
    for (int i = 0; i < 8; i++)
      add(127, 1, 0, 0, i == 7, (i == 7) ? 127 : 3, (i == 7) ? 127 : 4, (i == 7) ? 127 : 7);
    for (int i = 0; i < 8; i++)
      add(127, 1, 0, 0, i == 7, 127, 127, 127);
    for (int i = 0; i < 5; i++)
      add(100, 1, 0, 0, 0, 127, 127, 127);
    add(0, 0, 1, 0, 0, 127, 127, 127);
    for (int i = 0; i < 8; i++)
      add(10, 1, 0, 0, i == 7, (i == 7) ? 10 : 127, (i == 7) ? 10 : 127, (i == 7) ? 10 : 127);
    for (int i = 0; i < 7; i++)
      add(30, 1, 0, 0, 0, 10, 10, 10);
    add(50, 1, 1, 0, 0, 10, 10, 10);
    for (int i = 0; i < 8; i++)
      add(20, 1, 0, 0, i == 7, (i == 7) ? 20 : 10, (i == 7) ? 20 : 10, (i == 7) ? 20 : 10);

    rst_n = 1'b0; in = '0; strobe_in = 1'b0; clear = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      for (int g = 0; g < tbl[k].gap; g++) cyc(0, 0, 0);
      cyc(tbl[k].v, tbl[k].s, tbl[k].c);
      chk("tbl_so",    so_t,   tbl[k].so);
      chk("tbl_out",   out_t,  tbl[k].o);
      chk("tbl_out_r", out_r,  tbl[k].orr);
      chk("tbl_peak",  peak_t, tbl[k].p);
    end
    // Idle cycles after a completed window: outputs held, no strobe.
    for (int g = 0; g < 4; g++) cyc(0, 0, 0);
    chk("hold_out", out_t, 20);
    chk("hold_so",  so_t,  0);

    // Reset in the middle of a window after three samples.
    for (int i = 0; i < 3; i++) cyc(64, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out",  out_t,  0);
    chk("rst_peak", peak_t, 0);
    chk("rst_so",   so_t,   0);
    chk("rst_out1", out_1,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(64, 1, 0);
      chk("post_rst_so", so_t, (i == 7) ? 1 : 0);
    end
    chk("post_rst_out",  out_t,  64);
    chk("post_rst_peak", peak_t, 64);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(127, 0), $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
